// File: rtl/apb_pwm_audio_if.sv
// apb_pwm_audio_if: APB3 bus bundle between the MSS fabric master and the PWM audio slave.
interface apb_pwm_audio_if #(parameter int ADDR_W = 8);
  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [ADDR_W-1:0] PADDR;
  logic [31:0]       PWDATA;
  logic [31:0]       PRDATA;
  logic              PREADY;
  logic              PSLVERR;
  modport master (output PSEL, PENABLE, PWRITE, PADDR, PWDATA, input PRDATA, PREADY, PSLVERR);
  modport slave  (input PSEL, PENABLE, PWRITE, PADDR, PWDATA, output PRDATA, PREADY, PSLVERR);
endinterface

// File: rtl/apb_pwm_audio.sv
// apb_pwm_audio: APB3 slave buffering 8-bit audio samples in a FIFO and playing them as PWM.
// Optional APB error responses are enabled by defining APB_PWM_AUDIO_SLVERR_EN.
module apb_pwm_audio #(
  parameter int FIFO_DEPTH = 16,
  parameter int ADDR_W     = 8,
  parameter int DIV_W      = 16
) (
  input  logic                SYSCLK,
  input  logic                NSYSRESET,
  apb_pwm_audio_if.slave      apb,
  output logic                INT,
  output logic                PWM_OUT
);
  localparam int P  = $clog2(FIFO_DEPTH);
  localparam int L  = P + 1;
  localparam int AW = ADDR_W - 2;

  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [7:0]       mem_d [FIFO_DEPTH];
  logic [P-1:0]     rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [L-1:0]     level_q, level_d, thresh_q, thresh_d;
  logic [DIV_W-1:0] div_q, div_d, div_cnt_q, div_cnt_d;
  logic [7:0]       pwm_cnt_q, pwm_cnt_d, cur_q, cur_d;
  logic [31:0]      prdata_q, prdata_d, status, rd_val;
  logic             en_q, en_d, int_en_q, int_en_d, un_q, un_d, ov_q, ov_d;
  logic             int_q, int_d, pwm_q, pwm_d;
  logic             a_ctrl, a_status, a_div, a_thresh, a_data, err, wr_ok, rd_setup;
  logic             tick, empty, full, pop, push, wr_data, flush, clr_un, clr_ov;
  logic             unused_bits;
  logic [AW-1:0]    widx;

  assign widx     = apb.PADDR[ADDR_W-1:2];
  assign a_ctrl   = widx == AW'(0);
  assign a_status = widx == AW'(1);
  assign a_div    = widx == AW'(2);
  assign a_thresh = widx == AW'(3);
  assign a_data   = widx == AW'(4);

`ifdef APB_PWM_AUDIO_SLVERR_EN
  // Erroring accesses are also blocked from committing via wr_ok.
  assign err = apb.PSEL & apb.PENABLE &
               (!(a_ctrl | a_status | a_div | a_thresh | a_data) |
                (apb.PWRITE & a_status & |(apb.PWDATA & ~32'hC00)) |
                (!apb.PWRITE & a_data));
`else
  assign err = 1'b0;
`endif

  assign wr_ok       = apb.PSEL & apb.PENABLE & apb.PWRITE & !err;
  assign rd_setup    = apb.PSEL & !apb.PENABLE & !apb.PWRITE;
  assign apb.PRDATA  = prdata_q;
  assign apb.PREADY  = 1'b1;
  assign apb.PSLVERR = err;
  assign INT         = int_q;
  assign PWM_OUT     = pwm_q;
  assign unused_bits = ^{apb.PADDR[1:0], apb.PWDATA[31:12]};

  always_comb begin
    tick      = en_q & (div_cnt_q == div_q);
    empty     = level_q == '0;
    full      = level_q == L'(FIFO_DEPTH);
    pop       = tick & !empty;
    wr_data   = wr_ok & a_data;
    push      = wr_data & (!full | pop);
    flush     = wr_ok & a_ctrl & apb.PWDATA[2];
    clr_un    = wr_ok & a_status & apb.PWDATA[10];
    clr_ov    = wr_ok & a_status & apb.PWDATA[11];
    en_d      = wr_ok & a_ctrl ? apb.PWDATA[0] : en_q;
    int_en_d  = wr_ok & a_ctrl ? apb.PWDATA[1] : int_en_q;
    div_d     = wr_ok & a_div ? apb.PWDATA[DIV_W-1:0] : div_q;
    thresh_d  = wr_ok & a_thresh ? apb.PWDATA[L-1:0] : thresh_q;
    div_cnt_d = !en_q || tick ? '0 : div_cnt_q + DIV_W'(1);
    pwm_cnt_d = en_q ? pwm_cnt_q + 8'd1 : 8'd0;
    pwm_d     = en_q & (pwm_cnt_q < cur_q);
    cur_d     = pop ? mem_q[rd_ptr_q] : cur_q;
    rd_ptr_d  = flush ? '0 : pop ? rd_ptr_q + P'(1) : rd_ptr_q;
    wr_ptr_d  = flush ? '0 : push ? wr_ptr_q + P'(1) : wr_ptr_q;
    level_d   = flush ? '0 : level_q + L'(push) - L'(pop);
    mem_d     = mem_q;
    if (push) mem_d[wr_ptr_q] = apb.PWDATA[7:0];
    // A new set event beats a concurrent write-1-to-clear.
    un_d      = (tick & empty) | (un_q & !clr_un);
    ov_d      = (wr_data & full & !pop) | (ov_q & !clr_ov);
    int_d     = int_en_q & ((level_q <= thresh_q) | un_q);
    status    = '0;
    status[L-1:0] = level_q;
    status[8]  = empty;
    status[9]  = full;
    status[10] = un_q;
    status[11] = ov_q;
    rd_val    = a_ctrl ? {30'd0, int_en_q, en_q} : a_status ? status :
                a_div ? 32'(div_q) : a_thresh ? 32'(thresh_q) : 32'd0;
    prdata_d  = rd_setup ? rd_val : prdata_q;
  end

  always_ff @(posedge SYSCLK or negedge NSYSRESET) begin
    if (!NSYSRESET) begin
      mem_q     <= '{default: '0};
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      level_q   <= '0;
      thresh_q  <= '0;
      div_q     <= '0;
      div_cnt_q <= '0;
      pwm_cnt_q <= '0;
      cur_q     <= '0;
      prdata_q  <= '0;
      en_q      <= 1'b0;
      int_en_q  <= 1'b0;
      un_q      <= 1'b0;
      ov_q      <= 1'b0;
      int_q     <= 1'b0;
      pwm_q     <= 1'b0;
    end else begin
      mem_q     <= mem_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      level_q   <= level_d;
      thresh_q  <= thresh_d;
      div_q     <= div_d;
      div_cnt_q <= div_cnt_d;
      pwm_cnt_q <= pwm_cnt_d;
      cur_q     <= cur_d;
      prdata_q  <= prdata_d;
      en_q      <= en_d;
      int_en_q  <= int_en_d;
      un_q      <= un_d;
      ov_q      <= ov_d;
      int_q     <= int_d;
      pwm_q     <= pwm_d;
    end
  end
endmodule
